// File: rtl/pc_word_pkg.sv
// Shared definitions for the 32-bit PC word stream and the reassembled record.
package pc_word_pkg;
    localparam int NPCcode     = 7;
    localparam int NPCdata     = 20;
    localparam int NPCroute    = 5;
    localparam int NPCout      = NPCcode + NPCdata + NPCroute;
    localparam int Nchunks_max = 4;
    localparam int NCNT        = 2;
    localparam int NACC        = NPCdata * (Nchunks_max - 1);
    localparam int NPAY        = NPCdata * Nchunks_max;
    localparam int NCODES      = 1 << NPCcode;

    localparam int PC_DATA_LSB  = 0;
    localparam int PC_CODE_LSB  = NPCdata;
    localparam int PC_ROUTE_LSB = NPCdata + NPCcode;

    typedef struct packed {
        logic [NPCroute-1:0] route;
        logic [NPCcode-1:0]  code;
        logic [NPCdata-1:0]  data;
    } pc_word_t;

    typedef struct packed {
        logic [NPAY-1:0]     payload;
        logic [NPCcode-1:0]  code;
        logic [NPCroute-1:0] route;
        logic [NCNT-1:0]     nchunks;
    } deser_rec_t;

    // Chunks below idx come from the accumulator, chunk idx is the new data, the rest are zero.
    function automatic logic [NPAY-1:0] assemble_payload(
        input logic [NACC-1:0]    acc,
        input logic [NPCdata-1:0] data,
        input logic [NCNT-1:0]    idx
    );
        logic [NPAY-1:0] acc_ext;
        logic [NPAY-1:0] p;
        acc_ext = {{NPCdata{1'b0}}, acc};
        p       = {NPAY{1'b0}};
        for (int k = 0; k < Nchunks_max; k++) begin
            if (k < int'(idx)) begin
                p[k*NPCdata +: NPCdata] = acc_ext[k*NPCdata +: NPCdata];
            end else if (k == int'(idx)) begin
                p[k*NPCdata +: NPCdata] = data;
            end else begin
                p[k*NPCdata +: NPCdata] = {NPCdata{1'b0}};
            end
        end
        return p;
    endfunction
endpackage

// File: rtl/deser_state_chk.sv
// Checks that the per-code progress counter never runs past its configured chunk count.
module deser_state_chk
    import pc_word_pkg::*;
(
    input logic            clk,
    input logic            reset,
    input logic            rd_valid,
    input logic [NCNT-1:0] rd_prog,
    input logic [NCNT-1:0] rd_cfg
);
    prog_le_cfg: assert property (@(posedge clk) disable iff (reset) rd_valid |-> (rd_prog <= rd_cfg))
        else $error("deser_state_chk: prog exceeds cfg (prog=%0d cfg=%0d)", rd_prog, rd_cfg);
endmodule

// File: rtl/deser_state_mem.sv
// Per-code reassembly state: partial-chunk RAM plus prog/cfg flop arrays, one read and one write port.
module deser_state_mem
    import pc_word_pkg::*;
(
    input  logic               clk,
    input  logic               reset,
    input  logic [NPCcode-1:0] rd_addr,
    output logic [NCNT-1:0]    rd_prog,
    output logic [NCNT-1:0]    rd_cfg,
    output logic [NACC-1:0]    rd_acc,
    input  logic [NPCcode-1:0] wr_addr,
    input  logic               wr_prog_en,
    input  logic [NCNT-1:0]    wr_prog,
    input  logic               wr_cfg_en,
    input  logic [NCNT-1:0]    wr_cfg,
    input  logic               wr_acc_en,
    input  logic [NACC-1:0]    wr_acc
);
    logic [NCNT-1:0] prog_r [NCODES];
    logic [NCNT-1:0] cfg_r  [NCODES];
    logic [NACC-1:0] acc_r  [NCODES];
    logic            hit_s;

    assign hit_s = (wr_addr == rd_addr);

    // Progress and configuration flops; reset returns every code to single-chunk pass-through.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NCODES; i++) begin
                prog_r[i] <= {NCNT{1'b0}};
                cfg_r[i]  <= {NCNT{1'b0}};
            end
        end else begin
            if (wr_prog_en) prog_r[wr_addr] <= wr_prog;
            if (wr_cfg_en)  cfg_r[wr_addr]  <= wr_cfg;
        end
    end

    // Partial-chunk storage; left unreset because unused chunks are masked on output.
    always_ff @(posedge clk) begin
        if (wr_acc_en) acc_r[wr_addr] <= wr_acc;
    end

    // Read port with same-cycle write bypass so back-to-back chunks of one code see the update.
    always_comb begin
        rd_prog = prog_r[rd_addr];
        rd_cfg  = cfg_r[rd_addr];
        rd_acc  = acc_r[rd_addr];
        if (hit_s && wr_prog_en) rd_prog = wr_prog;
        else                     rd_prog = prog_r[rd_addr];
        if (hit_s && wr_cfg_en)  rd_cfg  = wr_cfg;
        else                     rd_cfg  = cfg_r[rd_addr];
        if (hit_s && wr_acc_en)  rd_acc  = wr_acc;
        else                     rd_acc  = acc_r[rd_addr];
    end
endmodule

// File: rtl/pc_out_deserializer.sv
// Reassembles 20-bit chunks of the PC word stream into full-width records, tracked per code.
module pc_out_deserializer
    import pc_word_pkg::*;
(
    input  logic                      clk,
    input  logic                      reset,
    input  logic [NPCout-1:0]         in_d,
    input  logic                      in_v,
    output logic                      in_a,
    input  logic [NPCcode+NCNT-1:0]   conf_d,
    input  logic                      conf_v,
    output logic                      conf_a,
    output logic [NPAY-1:0]           out_payload,
    output logic [NPCcode-1:0]        out_code,
    output logic [NPCroute-1:0]       out_route,
    output logic [NCNT-1:0]           out_nchunks,
    output logic                      out_v,
    input  logic                      out_a
);
    pc_word_t        in_word_s;
    logic            s1_v_r;
    pc_word_t        s1_word_r;
    logic            s2_v_r;
    pc_word_t        s2_word_r;
    logic [NCNT-1:0] s2_prog_r;
    logic [NCNT-1:0] s2_cfg_r;
    logic [NACC-1:0] s2_acc_r;
    logic            out_v_r;
    deser_rec_t      out_rec_r;

    logic            s2_done_s;
    logic            s2_retire_s;
    logic            s1_adv_s;
    logic            conf_xfer_s;
    logic            in_xfer_s;
    logic [NPAY-1:0] s2_payload_s;

    logic [NCNT-1:0]    mem_prog_s;
    logic [NCNT-1:0]    mem_cfg_s;
    logic [NACC-1:0]    mem_acc_s;
    logic [NPCcode-1:0] wr_addr_s;
    logic               wr_prog_en_s;
    logic [NCNT-1:0]    wr_prog_s;
    logic               wr_cfg_en_s;
    logic [NCNT-1:0]    wr_cfg_s;
    logic               wr_acc_en_s;
    logic [NACC-1:0]    wr_acc_s;

    assign in_word_s = '{route: in_d[PC_ROUTE_LSB +: NPCroute],
                         code:  in_d[PC_CODE_LSB  +: NPCcode],
                         data:  in_d[PC_DATA_LSB  +: NPCdata]};

    // A completing word may only leave S2 when the output register can take it.
    assign s2_done_s    = (s2_prog_r == s2_cfg_r);
    assign s2_retire_s  = s2_v_r && (!s2_done_s || !out_v_r || out_a);
    assign s1_adv_s     = s1_v_r && (!s2_v_r || s2_retire_s);
    assign conf_a       = !reset && !s1_v_r && !s2_v_r;
    assign conf_xfer_s  = conf_v && conf_a;
    assign in_a         = !reset && !conf_xfer_s && (!s1_v_r || s1_adv_s);
    assign in_xfer_s    = in_v && in_a;
    assign s2_payload_s = assemble_payload(s2_acc_r, s2_word_r.data, s2_prog_r);

    // Single write port shared by config writes and S2 retirement; the two never coincide.
    always_comb begin
        wr_addr_s    = {NPCcode{1'b0}};
        wr_prog_en_s = 1'b0;
        wr_prog_s    = {NCNT{1'b0}};
        wr_cfg_en_s  = 1'b0;
        wr_cfg_s     = {NCNT{1'b0}};
        wr_acc_en_s  = 1'b0;
        wr_acc_s     = {NACC{1'b0}};
        if (conf_xfer_s) begin
            wr_addr_s    = conf_d[NCNT +: NPCcode];
            wr_prog_en_s = 1'b1;
            wr_cfg_en_s  = 1'b1;
            wr_cfg_s     = conf_d[NCNT-1:0];
        end else if (s2_retire_s) begin
            wr_addr_s    = s2_word_r.code;
            wr_prog_en_s = 1'b1;
            wr_prog_s    = s2_done_s ? {NCNT{1'b0}} : (s2_prog_r + 2'd1);
            wr_acc_en_s  = !s2_done_s;
            wr_acc_s     = s2_payload_s[NACC-1:0];
        end else begin
            wr_prog_en_s = 1'b0;
        end
    end

    deser_state_mem u_state (
        .clk        (clk),
        .reset      (reset),
        .rd_addr    (s1_word_r.code),
        .rd_prog    (mem_prog_s),
        .rd_cfg     (mem_cfg_s),
        .rd_acc     (mem_acc_s),
        .wr_addr    (wr_addr_s),
        .wr_prog_en (wr_prog_en_s),
        .wr_prog    (wr_prog_s),
        .wr_cfg_en  (wr_cfg_en_s),
        .wr_cfg     (wr_cfg_s),
        .wr_acc_en  (wr_acc_en_s),
        .wr_acc     (wr_acc_s)
    );

    deser_state_chk u_chk (
        .clk      (clk),
        .reset    (reset),
        .rd_valid (s1_adv_s),
        .rd_prog  (mem_prog_s),
        .rd_cfg   (mem_cfg_s)
    );

    // S1: input word register.
    always_ff @(posedge clk) begin
        if (reset) begin
            s1_v_r <= 1'b0;
        end else if (in_xfer_s) begin
            s1_v_r    <= 1'b1;
            s1_word_r <= in_word_s;
        end else if (s1_adv_s) begin
            s1_v_r <= 1'b0;
        end
    end

    // S2: word plus the per-code state read (with bypass) on the S1 -> S2 transfer.
    always_ff @(posedge clk) begin
        if (reset) begin
            s2_v_r <= 1'b0;
        end else if (s1_adv_s) begin
            s2_v_r    <= 1'b1;
            s2_word_r <= s1_word_r;
            s2_prog_r <= mem_prog_s;
            s2_cfg_r  <= mem_cfg_s;
            s2_acc_r  <= mem_acc_s;
        end else if (s2_retire_s) begin
            s2_v_r <= 1'b0;
        end
    end

    // Output record register, held until acknowledged.
    always_ff @(posedge clk) begin
        if (reset) begin
            out_v_r   <= 1'b0;
            out_rec_r <= '0;
        end else if (s2_retire_s && s2_done_s) begin
            out_v_r   <= 1'b1;
            out_rec_r <= '{payload: s2_payload_s, code: s2_word_r.code,
                           route: s2_word_r.route, nchunks: s2_cfg_r};
        end else if (out_a) begin
            out_v_r <= 1'b0;
        end
    end

    assign out_v       = out_v_r;
    assign out_payload = out_rec_r.payload;
    assign out_code    = out_rec_r.code;
    assign out_route   = out_rec_r.route;
    assign out_nchunks = out_rec_r.nchunks;
endmodule

// File: tb/tb_pc_out_deserializer.sv
// Directed bench for pc_out_deserializer: latency, forwarding, interleave, backpressure, reconfig, reset.
module tb_pc_out_deserializer;
    logic        clk;
    logic        reset;
    logic [31:0] in_d;
    logic        in_v;
    logic        in_a;
    logic [8:0]  conf_d;
    logic        conf_v;
    logic        conf_a;
    logic [79:0] out_payload;
    logic [6:0]  out_code;
    logic [4:0]  out_route;
    logic [1:0]  out_nchunks;
    logic        out_v;
    logic        out_a;

    int checks = 0;
    int errors = 0;

    pc_out_deserializer dut (
        .clk         (clk),
        .reset       (reset),
        .in_d        (in_d),
        .in_v        (in_v),
        .in_a        (in_a),
        .conf_d      (conf_d),
        .conf_v      (conf_v),
        .conf_a      (conf_a),
        .out_payload (out_payload),
        .out_code    (out_code),
        .out_route   (out_route),
        .out_nchunks (out_nchunks),
        .out_v       (out_v),
        .out_a       (out_a)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Called and returns at a falling edge.
    task automatic send(input logic [6:0] code, input logic [19:0] data, input logic [4:0] route);
        int n;
        n = 0;
        in_d = {route, code, data};
        in_v = 1'b1;
        #1;
        while (!in_a && n < 50) begin
            @(negedge clk); #1; n++;
        end
        check("send_in_a", in_a, 1'b1);
        @(posedge clk);
        @(negedge clk);
        in_v = 1'b0;
    endtask

    task automatic configure(input logic [6:0] code, input logic [1:0] nm1);
        int n;
        n = 0;
        conf_d = {code, nm1};
        conf_v = 1'b1;
        #1;
        while (!conf_a && n < 50) begin
            @(negedge clk); #1; n++;
        end
        check("conf_a", conf_a, 1'b1);
        @(posedge clk);
        @(negedge clk);
        conf_v = 1'b0;
    endtask

    task automatic expect_out(input string tag, input logic [79:0] pay, input logic [6:0] code,
                              input logic [4:0] route, input logic [1:0] nch);
        int n;
        n = 0;
        #1;
        while (!out_v && n < 50) begin
            @(negedge clk); #1; n++;
        end
        check({tag, "_v"}, out_v, 1'b1);
        check({tag, "_payload"}, out_payload, pay);
        check({tag, "_code"}, out_code, code);
        check({tag, "_route"}, out_route, route);
        check({tag, "_nchunks"}, out_nchunks, nch);
        out_a = 1'b1;
        @(posedge clk);
        @(negedge clk);
        out_a = 1'b0;
    endtask

    initial begin
        reset  = 1'b1;
        in_d   = 32'd0;
        in_v   = 1'b0;
        conf_d = 9'd0;
        conf_v = 1'b0;
        out_a  = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_out_v", out_v, 1'b0);
        check("rst_payload", out_payload, 80'd0);
        check("rst_code", out_code, 7'd0);
        check("rst_route", out_route, 5'd0);
        check("rst_nchunks", out_nchunks, 2'd0);
        check("rst_in_a", in_a, 1'b0);
        check("rst_conf_a", conf_a, 1'b0);
        reset = 1'b0;
        @(negedge clk);

        // Single-chunk pass-through with exact two-edge latency.
        send(7'h05, 20'hABCDE, 5'd3);
        check("lat_t0", out_v, 1'b0);
        @(negedge clk);
        check("lat_t1", out_v, 1'b0);
        @(negedge clk);
        check("lat_t2", out_v, 1'b1);
        expect_out("pass", 80'h0000000000000ABCDE, 7'h05, 5'd3, 2'd0);

        // Three back-to-back chunks of one code exercise the bypass.
        configure(7'h10, 2'd2);
        send(7'h10, 20'h11111, 5'd1);
        send(7'h10, 20'h22222, 5'd2);
        send(7'h10, 20'h33333, 5'd7);
        expect_out("fwd", 80'h00000333332222211111, 7'h10, 5'd7, 2'd2);

        // Interleaved codes complete in completion order.
        configure(7'h10, 2'd1);
        configure(7'h11, 2'd1);
        send(7'h10, 20'hAAAAA, 5'd4);
        send(7'h11, 20'hBBBBB, 5'd5);
        send(7'h11, 20'hCCCCC, 5'd6);
        send(7'h10, 20'hDDDDD, 5'd8);
        expect_out("ilv11", 80'h0000000000CCCCCBBBBB, 7'h11, 5'd6, 2'd1);
        expect_out("ilv10", 80'h0000000000DDDDDAAAAA, 7'h10, 5'd8, 2'd1);

        // Backpressure: three words fill the pipe, the fourth is held off.
        send(7'h20, 20'h00001, 5'd1);
        send(7'h21, 20'h00002, 5'd2);
        send(7'h22, 20'h00003, 5'd3);
        in_d = {5'd4, 7'h23, 20'h00004};
        in_v = 1'b1;
        #1;
        check("bp_stall0", in_a, 1'b0);
        @(negedge clk);
        #1;
        check("bp_stall1", in_a, 1'b0);
        check("bp_w1_v", out_v, 1'b1);
        check("bp_w1_payload", out_payload, 80'h00001);
        check("bp_w1_code", out_code, 7'h20);
        out_a = 1'b1;
        #1;
        check("bp_release", in_a, 1'b1);
        @(posedge clk);
        @(negedge clk);
        out_a = 1'b0;
        in_v  = 1'b0;
        expect_out("bp_w2", 80'h00002, 7'h21, 5'd2, 2'd0);
        expect_out("bp_w3", 80'h00003, 7'h22, 5'd3, 2'd0);
        expect_out("bp_w4", 80'h00004, 7'h23, 5'd4, 2'd0);
        repeat (3) @(negedge clk);
        check("bp_no_dup", out_v, 1'b0);

        // Reconfig discards a partial word; config wins over a simultaneous input word.
        configure(7'h10, 2'd2);
        send(7'h10, 20'h0AAAA, 5'd9);
        repeat (3) @(negedge clk);
        conf_d = {7'h10, 2'd2};
        conf_v = 1'b1;
        in_d   = {5'd10, 7'h10, 20'h01234};
        in_v   = 1'b1;
        #1;
        check("prio_conf_a", conf_a, 1'b1);
        check("prio_in_a", in_a, 1'b0);
        @(posedge clk);
        @(negedge clk);
        conf_v = 1'b0;
        #1;
        check("prio_in_a_after", in_a, 1'b1);
        @(posedge clk);
        @(negedge clk);
        in_v = 1'b0;
        send(7'h10, 20'h05678, 5'd11);
        check("reconf_no_early", out_v, 1'b0);
        send(7'h10, 20'h09ABC, 5'd12);
        expect_out("reconf", 80'h0000009ABC0567801234, 7'h10, 5'd12, 2'd2);
        repeat (3) @(negedge clk);
        check("reconf_single", out_v, 1'b0);

        // Reset mid-word returns the code to single-chunk pass-through.
        configure(7'h30, 2'd3);
        send(7'h30, 20'h5A5A5, 5'd1);
        send(7'h30, 20'hA5A5A, 5'd2);
        reset = 1'b1;
        #1;
        check("mid_rst_in_a", in_a, 1'b0);
        check("mid_rst_conf_a", conf_a, 1'b0);
        @(negedge clk);
        reset = 1'b0;
        check("post_rst_out_v", out_v, 1'b0);
        send(7'h30, 20'h00C01, 5'd3);
        send(7'h30, 20'h00C02, 5'd4);
        expect_out("rst_c1", 80'h00C01, 7'h30, 5'd3, 2'd0);
        send(7'h30, 20'h00C03, 5'd5);
        expect_out("rst_c2", 80'h00C02, 7'h30, 5'd4, 2'd0);
        send(7'h30, 20'h00C04, 5'd6);
        expect_out("rst_c3", 80'h00C03, 7'h30, 5'd5, 2'd0);
        expect_out("rst_c4", 80'h00C04, 7'h30, 5'd6, 2'd0);
        repeat (3) @(negedge clk);
        check("rst_no_extra", out_v, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
